block_seq_ctrl: RTL and testbench

- Upstream driver and checker for the 2-bit select/output block.
- Generates the S0/S1 select codes and the I1 data value that feed the block.
- Samples the block's O0/O1 outputs on return and checks them against the expected function: O0 = S0 & ~I1, O1 = S1 & ~I1.
- Counts mismatching steps and reports pass/fail with a start/done handshake.

---
 rtl/block_seq_ctrl.sv | 138 +++++++++++++
 tb/tb_block_seq_ctrl.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/block_seq_ctrl.sv
// block_seq_ctrl
//   Upstream driver and checker for the 2-bit select/output block. Walks the
//   block inputs {I1,S0,S1} through all eight codes, holds each one for DWELL
//   cycles, then samples the returned O0/O1. It checks the samples against
//   O0 = S0 & ~I1 and O1 = S1 & ~I1 and counts the steps that mismatch.
//
// Parameters
//   DWELL  cycles each step is held before sampling (2..255)
//   ERR_W  width of the saturating mismatch counter
//
// Ports
//   clk      system clock, rising edge
//   rst_n    asynchronous active-low reset
//   start    one-cycle request to run a sequence (ignored unless idle)
//   abort    drop back to idle at the next edge, no done pulse
//   o0, o1   block outputs returned for checking
//   s0, s1   block select drives
//   i1_drv   block I1 drive
//   busy     high while a sequence runs
//   done     one-cycle pulse at sequence end
//   pass     last sequence had zero mismatches; held until the next start
//   err_cnt  mismatching steps in the last or current sequence
module block_seq_ctrl #(
  parameter int unsigned DWELL = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             o0,
  input  logic             o1,
  output logic             s0,
  output logic             s1,
  output logic             i1_drv,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t           state;
  logic [2:0]       step;
  logic [7:0]       dwell;
  logic             mismatch;
  logic [ERR_W-1:0] err_next;

  // Compare against the drives currently on the block; one mismatch per
  // step regardless of how many bits differ.
  always_comb begin
    mismatch = (o0 != (s0 & ~i1_drv)) || (o1 != (s1 & ~i1_drv));
    err_next = err_cnt;
    if (mismatch && (err_cnt != '1)) begin
      err_next = err_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      step    <= '0;
      dwell   <= '0;
      s0      <= 1'b0;
      s1      <= 1'b0;
      i1_drv  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      pass    <= 1'b0;
      err_cnt <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          s0     <= 1'b0;
          s1     <= 1'b0;
          i1_drv <= 1'b0;
          if (start && !abort) begin
            err_cnt <= '0;
            pass    <= 1'b0;
            step    <= '0;
            dwell   <= '0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end

        RUN: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            pass   <= 1'b0;
            step   <= '0;
            dwell  <= '0;
            s0     <= 1'b0;
            s1     <= 1'b0;
            i1_drv <= 1'b0;
          end else if (dwell == DWELL_LAST) begin
            err_cnt <= err_next;
            dwell   <= '0;
            if (step == 3'd7) begin
              // pass uses err_next so the last step's result is included
              state  <= FIN;
              busy   <= 1'b0;
              done   <= 1'b1;
              pass   <= (err_next == '0);
              step   <= '0;
              s0     <= 1'b0;
              s1     <= 1'b0;
              i1_drv <= 1'b0;
            end else begin
              step                 <= step + 3'd1;
              {i1_drv, s0, s1}     <= step + 3'd1;
            end
          end else begin
            dwell <= dwell + 8'd1;
          end
        end

        FIN: begin
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_block_seq_ctrl.sv
module tb_block_seq_ctrl;

  localparam int unsigned DW      = 4;
  localparam int          RUN_CYC = 8 * DW;

  logic       clk = 1'b0;
  logic       rst_n, start, abort;
  logic       o0, o1, s0, s1, i1_drv, busy, done, pass;
  logic [7:0] err_cnt;
  logic       o0_b, o1_b, s0_b, s1_b, i1_b, busy_b, done_b, pass_b;
  logic [1:0] err_b;

  int fault_mode = 0;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  block_seq_ctrl #(.DWELL(DW), .ERR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .o0(o0), .o1(o1), .s0(s0), .s1(s1), .i1_drv(i1_drv),
    .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt)
  );

  block_seq_ctrl #(.DWELL(DW), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .o0(o0_b), .o1(o1_b), .s0(s0_b), .s1(s1_b), .i1_drv(i1_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_b)
  );

  // Block model: ideal function, optionally with a planted fault.
  // mode 1: O0 stuck at 0; mode 2: O1 inverted.
  always_comb begin
    o0 = s0 & ~i1_drv;
    o1 = s1 & ~i1_drv;
    if (fault_mode == 1) o0 = 1'b0;
    if (fault_mode == 2) o1 = ~(s1 & ~i1_drv);
    o0_b = s0_b & ~i1_b;
    o1_b = s1_b & ~i1_b;
    if (fault_mode == 1) o0_b = 1'b0;
    if (fault_mode == 2) o1_b = ~(s1_b & ~i1_b);
  end

  typedef struct {
    int mode;
    int restart_at;
    int abort_at;
    int reset_at;
    int exp_err;
    int exp_pass;
    int exp_err2;
  } vec_t;

  typedef struct {
    int err;
    int err2;
    int pss;
  } sb_t;

  vec_t rows[9];
  sb_t  sb_q[$];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic run_row(input vec_t v);
    bit  stopped = 0;
    int  exp_vec;
    sb_t e;
    fault_mode = v.mode;
    @(negedge clk);
    start = 1'b1;
    if (v.abort_at == 0 && v.reset_at == 0)
      sb_q.push_back('{err: v.exp_err, err2: v.exp_err2, pss: v.exp_pass});
    @(negedge clk);
    for (int c = 1; c <= RUN_CYC + 2; c++) begin
      start = 1'b0;
      abort = 1'b0;
      rst_n = 1'b1;
      // expected {busy, done, i1_drv, s0, s1} in cycle c after the start edge
      if (stopped || c > RUN_CYC + 1) exp_vec = 0;
      else if (c == RUN_CYC + 1)      exp_vec = 5'b01000;
      else                            exp_vec = 16 | ((c - 1) / DW);
      chk($sformatf("cyc%0d", c), int'({busy, done, i1_drv, s0, s1}), exp_vec);
      if (done) begin
        n_tests++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_done: got done=1 expected no pending run");
        end else begin
          e = sb_q.pop_front();
          chk("sb_err", int'(err_cnt), e.err);
          chk("sb_err_sat", int'(err_b), e.err2);
          chk("sb_pass", int'(pass), e.pss);
        end
      end
      if (c == v.restart_at) start = 1'b1;
      if (c == v.abort_at) begin
        abort   = 1'b1;
        stopped = 1;
      end
      if (c == v.reset_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_rst", int'({busy, done, pass, i1_drv, s0, s1, err_cnt, err_b}), 0);
        stopped = 1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b1;
    chk("end_err", int'(err_cnt), v.exp_err);
    chk("end_err_sat", int'(err_b), v.exp_err2);
    chk("end_pass", int'(pass), v.exp_pass);
    chk("end_busy", int'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //        mode restart abort reset err pass err2
    rows[0] = '{0, 0,  0,  0,  0, 1, 0};  // nominal
    rows[1] = '{1, 0,  0,  0,  2, 0, 2};  // o0 stuck at 0
    rows[2] = '{2, 0,  0,  0,  8, 0, 3};  // o1 inverted, narrow counter saturates
    rows[3] = '{0, 10, 0,  0,  0, 1, 0};  // start while busy ignored
    rows[4] = '{2, 0,  12, 0,  2, 0, 2};  // abort after two sampled steps
    rows[5] = '{0, 0,  0,  0,  0, 1, 0};  // normal run after abort
    rows[6] = '{1, 0,  0,  20, 0, 0, 0};  // reset pulse mid-run
    rows[7] = '{0, 0,  0,  0,  0, 1, 0};  // full run after reset
    rows[8] = '{1, 33, 0,  0,  2, 0, 2};  // start in FIN cycle ignored

    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_state", int'({busy, done, pass, i1_drv, s0, s1, err_cnt}), 0);
    chk("reset_state_sat", int'(err_b), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 9; r++) run_row(rows[r]);

    // abort together with start in IDLE: stay idle, pass from the last run held
    rows[0].mode = 0;
    run_row(rows[0]);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("abort_start_idle", int'({busy, done, i1_drv, s0, s1}), 0);
      @(negedge clk);
    end
    chk("abort_start_pass_held", int'(pass), 1);

    chk("sb_empty", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
